// File: rtl/jackpot_player.sv
// Automated jackpot opponent: tracks the lit LED, presses the matching switch
// after a reaction delay and keeps saturating win/miss statistics.
// Optional build macro: JACKPOT_PLAYER_SYNC_EN (2-flop synchronizer on LEDS).
module jackpot_player #(
  parameter int unsigned REACTION_CYCLES = 3,
  parameter int unsigned PRESS_TIMEOUT   = 16,
  parameter logic [3:0]  WIN_PATTERN     = 4'b1111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] LEDS,
  output logic [3:0] SWITCHES,
  output logic       busy,
  output logic       won,
  output logic [7:0] win_count,
  output logic [7:0] miss_count
);

  localparam int unsigned LED_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TMR_W = 8;

  // Timers count down to zero, so load one less than the cycle count.
  localparam logic [TMR_W-1:0] REACT_LOAD = TMR_W'(REACTION_CYCLES - 1);
  localparam logic [TMR_W-1:0] PRESS_LOAD = TMR_W'(PRESS_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TRACK = 3'd1,
    S_AIM   = 3'd2,
    S_PRESS = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [LED_W-1:0]   target, target_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic [LED_W-1:0]   switches_n;
  logic               busy_n;
  logic               won_n;
  logic [CNT_W-1:0]   win_count_n;
  logic [CNT_W-1:0]   miss_count_n;

  logic [LED_W-1:0]   led_l;
  logic               l_onehot_c;
  logic               l_win_c;

`ifdef JACKPOT_PLAYER_SYNC_EN
  logic [LED_W-1:0] led_meta;
  logic [LED_W-1:0] led_sync;

  // Two-flop synchronizer for LEDs coming from another clock domain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      led_meta <= '0;
      led_sync <= '0;
    end else begin
      led_meta <= LEDS;
      led_sync <= led_meta;
    end
  end

  assign led_l = led_sync;
`else
  assign led_l = LEDS;
`endif

  // A target is a single lit LED that is not itself the jackpot pattern.
  assign l_win_c    = (led_l == WIN_PATTERN);
  assign l_onehot_c = (led_l != '0)
                   && ((led_l & (led_l - LED_W'(1))) == '0)
                   && !l_win_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // State and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      target     <= '0;
      timer      <= '0;
      SWITCHES   <= '0;
      busy       <= 1'b0;
      won        <= 1'b0;
      win_count  <= '0;
      miss_count <= '0;
    end else begin
      state      <= state_n;
      target     <= target_n;
      timer      <= timer_n;
      SWITCHES   <= switches_n;
      busy       <= busy_n;
      won        <= won_n;
      win_count  <= win_count_n;
      miss_count <= miss_count_n;
    end
  end

  // Next-state, next-output and statistics logic.
  always_comb begin
    state_n      = state;
    target_n     = target;
    timer_n      = timer;
    switches_n   = '0;
    won_n        = 1'b0;
    win_count_n  = win_count;
    miss_count_n = miss_count;

    unique case (state)
      S_IDLE: begin
        if (enable) state_n = S_TRACK;
      end

      S_TRACK: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (l_onehot_c) begin
          target_n = led_l;
          timer_n  = REACT_LOAD;
          state_n  = S_AIM;
        end
      end

      S_AIM: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (timer != '0) begin
          timer_n = timer - TMR_W'(1);
        end else if (led_l == target) begin
          switches_n = target;
          timer_n    = PRESS_LOAD;
          state_n    = S_PRESS;
        end else begin
          miss_count_n = sat_inc(miss_count);
          state_n      = S_TRACK;
        end
      end

      // A win sampled on the last timeout edge still counts as a win.
      S_PRESS: begin
        if (!enable) begin
          state_n = S_IDLE;
        end else if (l_win_c) begin
          won_n       = 1'b1;
          win_count_n = sat_inc(win_count);
          state_n     = S_DONE;
        end else if (timer == '0) begin
          miss_count_n = sat_inc(miss_count);
          state_n      = S_TRACK;
        end else begin
          timer_n    = timer - TMR_W'(1);
          switches_n = target;
        end
      end

      // Hold until the game clears its win display, even when disabled.
      S_DONE: begin
        if (!l_win_c) state_n = enable ? S_TRACK : S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_jackpot_player.sv
// Directed bench for jackpot_player in its default (unsynchronized) build.
`timescale 1ns/1ps
module tb_jackpot_player;

  logic       clock;
  logic       reset;
  logic       enable;
  logic [3:0] LEDS;
  logic [3:0] SWITCHES;
  logic       busy;
  logic       won;
  logic [7:0] win_count;
  logic [7:0] miss_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       en;
    logic [3:0] leds;
    logic [3:0] sw;
    logic       busy;
    logic       won;
    logic [7:0] wc;
    logic [7:0] mc;
  } vec_t;

  vec_t vecs[$];

  jackpot_player #(
    .REACTION_CYCLES(3),
    .PRESS_TIMEOUT  (16),
    .WIN_PATTERN    (4'b1111)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .LEDS      (LEDS),
    .SWITCHES  (SWITCHES),
    .busy      (busy),
    .won       (won),
    .win_count (win_count),
    .miss_count(miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(input logic en, input logic [3:0] leds, input logic [3:0] sw,
                              input logic bz, input logic wn, input logic [7:0] wc,
                              input logic [7:0] mc);
    vec_t v;
    v.en = en; v.leds = leds; v.sw = sw; v.busy = bz; v.won = wn; v.wc = wc; v.mc = mc;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] sw, input logic bz,
                           input logic wn, input logic [7:0] wc, input logic [7:0] mc);
    check({tag, ".SWITCHES"},   32'(SWITCHES),   32'(sw));
    check({tag, ".busy"},       32'(busy),       32'(bz));
    check({tag, ".won"},        32'(won),        32'(wn));
    check({tag, ".win_count"},  32'(win_count),  32'(wc));
    check({tag, ".miss_count"}, 32'(miss_count), 32'(mc));
  endtask

  task automatic step(input logic en, input logic [3:0] leds);
    enable = en;
    LEDS   = leds;
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] exp_m;

    // Reset, enable-off idle, first win, DONE hold, enable drop in PRESS
    add(0, 4'b0100, 4'b0000, 0, 0, 0, 0);
    add(0, 4'b0100, 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(1, 4'b0010, 4'b0000, 1, 0, 0, 0);
    add(1, 4'b0010, 4'b0010, 1, 0, 0, 0);
    add(1, 4'b1111, 4'b0000, 1, 1, 1, 0);
    add(1, 4'b1111, 4'b0000, 1, 0, 1, 0);
    add(1, 4'b1111, 4'b0000, 1, 0, 1, 0);
    for (int i = 0; i < 4; i++) add(1, 4'b0001, 4'b0000, 1, 0, 1, 0);
    add(1, 4'b0001, 4'b0001, 1, 0, 1, 0);
    add(0, 4'b0001, 4'b0000, 0, 0, 1, 0);
    // Rotating LEDs: every attempt loses its target
    add(1, 4'b0001, 4'b0000, 1, 0, 1, 0);
    add(1, 4'b0001, 4'b0000, 1, 0, 1, 0);
    add(1, 4'b0010, 4'b0000, 1, 0, 1, 0);
    add(1, 4'b0010, 4'b0000, 1, 0, 1, 0);
    add(1, 4'b0100, 4'b0000, 1, 0, 1, 1);
    add(1, 4'b0100, 4'b0000, 1, 0, 1, 1);
    add(1, 4'b1000, 4'b0000, 1, 0, 1, 1);
    add(1, 4'b1000, 4'b0000, 1, 0, 1, 1);
    add(1, 4'b0001, 4'b0000, 1, 0, 1, 2);
    add(1, 4'b0001, 4'b0000, 1, 0, 1, 2);
    add(1, 4'b0010, 4'b0000, 1, 0, 1, 2);
    add(1, 4'b0010, 4'b0000, 1, 0, 1, 2);
    add(1, 4'b0100, 4'b0000, 1, 0, 1, 3);
    // Steady 1000 with no win: 16-cycle press, timeout, re-aim
    for (int i = 0; i < 3; i++) add(1, 4'b1000, 4'b0000, 1, 0, 1, 3);
    for (int i = 0; i < 16; i++) add(1, 4'b1000, 4'b1000, 1, 0, 1, 3);
    add(1, 4'b1000, 4'b0000, 1, 0, 1, 4);
    for (int i = 0; i < 3; i++) add(1, 4'b1000, 4'b0000, 1, 0, 1, 4);
    add(1, 4'b1000, 4'b1000, 1, 0, 1, 4);

    enable = 1'b0;
    LEDS   = 4'b0100;
    reset  = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_all("reset_held", 4'b0000, 0, 0, 8'd0, 8'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].leds);
      check_all($sformatf("vec%0d", i), vecs[i].sw, vecs[i].busy, vecs[i].won,
                vecs[i].wc, vecs[i].mc);
    end

    // Async reset mid-PRESS clears everything before the next edge
    check("pre_reset_press", 32'(SWITCHES), 32'(4'b1000));
    #3 reset = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 0, 0, 8'd0, 8'd0);
    @(posedge clock);
    #1 reset = 1'b0;

    // enable dropped in DONE leaves only after the win pattern clears
    step(1, 4'b0010); check_all("d_track", 4'b0000, 1, 0, 8'd0, 8'd0);
    step(1, 4'b0010);
    step(1, 4'b0010);
    step(1, 4'b0010); check_all("d_aim", 4'b0000, 1, 0, 8'd0, 8'd0);
    step(1, 4'b0010); check_all("d_press", 4'b0010, 1, 0, 8'd0, 8'd0);
    step(1, 4'b1111); check_all("d_win", 4'b0000, 1, 1, 8'd1, 8'd0);
    step(0, 4'b1111); check_all("d_hold0", 4'b0000, 1, 0, 8'd1, 8'd0);
    step(0, 4'b1111); check_all("d_hold1", 4'b0000, 1, 0, 8'd1, 8'd0);
    step(0, 4'b0000); check_all("d_idle", 4'b0000, 0, 0, 8'd1, 8'd0);
    step(0, 4'b0000); check_all("d_idle2", 4'b0000, 0, 0, 8'd1, 8'd0);

    // Miss counter saturation: 300 lost targets
    step(1, 4'b0001);
    exp_m = 8'd0;
    for (int a = 0; a < 300; a++) begin
      step(1, 4'b0001);
      step(1, 4'b0001);
      step(1, 4'b0001);
      step(1, 4'b0010);
      exp_m = (exp_m == 8'hFF) ? exp_m : exp_m + 8'd1;
      check($sformatf("sat%0d.miss_count", a), 32'(miss_count), 32'(exp_m));
      check($sformatf("sat%0d.SWITCHES", a), 32'(SWITCHES), 32'(4'b0000));
    end
    check("sat_final.win_count", 32'(win_count), 32'(8'd1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
